// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display driver:
// FSM states, active-low segment patterns, anode patterns and the BCD adjust step.
package ssd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      LATCH   = 2'd2
   } state_t;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] ANODE_THOU = 4'b0111;
   localparam logic [3:0] ANODE_HUND = 4'b1011;
   localparam logic [3:0] ANODE_TENS = 4'b1101;
   localparam logic [3:0] ANODE_UNIT = 4'b1110;

   // Double-dabble correction: any nibble >= 5 would overflow past 9 after the shift.
   function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
      logic [15:0] r;
      r = b;
      for (int i = 0; i < 4; i++) begin
         if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/ssd_seg_decoder.sv
// Combinational BCD digit to active-low {a..g} segment decoder with a blank override.
module ssd_seg_decoder
   import ssd_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/ssd_display_driver.sv
// Four-digit multiplexed display driver: 13-bit binary to BCD by double-dabble, then refresh scan.
// Define SSD_LEADING_ZERO_BLANK_EN to blank leading zero digits above the units digit.
module ssd_display_driver
   import ssd_pkg::*;
#(
   parameter int REFRESH_BITS = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [12:0] ssd,
   input  logic        load,
   output logic        busy,
   output logic [3:0]  Anode,
   output logic [6:0]  LED_out
);

   state_t                  state_q, state_d;
   logic [12:0]             bin_q, bin_d;
   logic [15:0]             bcd_q, bcd_d, bcd_adj;
   logic [3:0]              cnt_q, cnt_d;
   logic [15:0]             disp_q, disp_d;
   logic [REFRESH_BITS-1:0] refresh_q;
   logic [6:0]              seg_q, seg_d;
   logic [1:0]              sel;
   logic [3:0]              digit;
   logic                    blank;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         bin_q     <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         disp_q    <= '0;
         refresh_q <= '0;
         seg_q     <= SEG_0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
         disp_q    <= disp_d;
         refresh_q <= refresh_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
         seg_q     <= seg_d;
      end
   end

   assign bcd_adj = bcd_adjust(bcd_q);

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               bin_d   = ssd;
               bcd_d   = '0;
               cnt_d   = 4'd13;
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            busy           = 1'b1;
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d          = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = LATCH;
         end
         LATCH: begin
            busy    = 1'b1;
            disp_d  = bcd_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign sel = refresh_q[REFRESH_BITS-1 -: 2];

   // Digit select; the decoded segments are registered, so LED_out trails Anode by one clock.
   always_comb begin
      Anode = ANODE_THOU;
      digit = disp_q[15:12];
      blank = 1'b0;
      case (sel)
         2'd0: begin Anode = ANODE_THOU; digit = disp_q[15:12]; end
         2'd1: begin Anode = ANODE_HUND; digit = disp_q[11:8];  end
         2'd2: begin Anode = ANODE_TENS; digit = disp_q[7:4];   end
         default: begin Anode = ANODE_UNIT; digit = disp_q[3:0]; end
      endcase
`ifdef SSD_LEADING_ZERO_BLANK_EN
      case (sel)
         2'd0:    blank = (disp_q[15:12] == 4'd0);
         2'd1:    blank = (disp_q[15:8]  == 8'd0);
         2'd2:    blank = (disp_q[15:4]  == 12'd0);
         default: blank = 1'b0;
      endcase
`else
      blank = 1'b0;
`endif
   end

   ssd_seg_decoder u_dec (
      .digit_i (digit),
      .blank_i (blank),
      .seg_o   (seg_d)
   );

   assign LED_out = seg_q;

endmodule

// File: tb/tb_ssd_display_driver.sv
// Scoreboard bench for ssd_display_driver: expected display frames are queued at each load,
// and a monitor scans one full refresh frame whenever busy drops.
module tb_ssd_display_driver;

   localparam int RB = 4;
   localparam logic [6:0] BLANK = 7'b1111111;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [12:0] ssd;
   logic        busy;
   logic [3:0]  Anode;
   logic [6:0]  LED_out;

   int          errors = 0;
   int          checks = 0;
   logic [27:0] sb[$];
   logic        mon_en = 1'b0;

   ssd_display_driver #(.REFRESH_BITS(RB)) dut (
      .clk     (clk),
      .reset   (reset),
      .ssd     (ssd),
      .load    (load),
      .busy    (busy),
      .Anode   (Anode),
      .LED_out (LED_out)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return BLANK;
      endcase
   endfunction

   // Packed as {thousands, hundreds, tens, units}, 7 bits each.
   function automatic logic [27:0] frame(input int d3, input int d2, input int d1, input int d0);
      logic [6:0] s3, s2, s1, s0;
      s3 = seg_of(d3); s2 = seg_of(d2); s1 = seg_of(d1); s0 = seg_of(d0);
`ifdef SSD_LEADING_ZERO_BLANK_EN
      if (d3 == 0) s3 = BLANK;
      if (d3 == 0 && d2 == 0) s2 = BLANK;
      if (d3 == 0 && d2 == 0 && d1 == 0) s1 = BLANK;
`endif
      return {s3, s2, s1, s0};
   endfunction

   function automatic int aidx(input logic [3:0] a);
      case (a)
         4'b0111: return 3;
         4'b1011: return 2;
         4'b1101: return 1;
         4'b1110: return 0;
         default: return -1;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic do_load(input int v);
      @(negedge clk);
      ssd  = 13'(v);
      load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (mon_en) check("anode_one_low", $countones(~Anode), 1);
   end

   // Monitor: on each busy fall, pop one expected frame and scan a full refresh frame.
   initial begin
      logic [27:0] exp;
      logic [3:0]  prev;
      logic [3:0]  bad, seen;
      logic [6:0]  got [4];
      int          idx;
      wait (mon_en);
      forever begin
         @(negedge busy);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got=busy_fall expected=no_transaction");
            continue;
         end
         exp = sb.pop_front();
         wait (!reset);
         @(negedge clk);
         @(negedge clk);
         prev = Anode;
         bad  = '0;
         seen = '0;
         for (int k = 0; k < 4; k++) got[k] = 7'bx;
         repeat (16) begin
            @(negedge clk);
            idx = aidx(prev);
            if (idx >= 0) begin
               seen[idx] = 1'b1;
               if (LED_out !== exp[idx*7 +: 7]) begin
                  bad[idx] = 1'b1;
                  got[idx] = LED_out;
               end
            end
            prev = Anode;
         end
         for (int d = 3; d >= 0; d--) begin
            checks++;
            if (bad[d] || !seen[d]) begin
               errors++;
               $display("FAIL digit%0d_segments: got=%b expected=%b seen=%0d", d, got[d], exp[d*7 +: 7], seen[d]);
            end
         end
      end
   end

   initial begin
      int n;
      int cnt [4];
      logic [3:0] pat [4];
      pat[0] = 4'b0111; pat[1] = 4'b1011; pat[2] = 4'b1101; pat[3] = 4'b1110;

      reset = 1'b1;
      load  = 1'b0;
      ssd   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_anode", Anode, 4'b0111);
      check("reset_led", LED_out, 7'b0000001);
      reset = 1'b0;
      mon_en = 1'b1;

      sb.push_back(frame(1, 2, 3, 4));
      do_load(1234);
      n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("busy_len_1234", n, 14);
      idle(40);

      sb.push_back(frame(8, 1, 9, 1));
      do_load(8191);
      idle(50);

      sb.push_back(frame(0, 0, 0, 0));
      do_load(0);
      idle(50);

      // Second load lands mid-conversion and must be dropped.
      sb.push_back(frame(5, 6, 7, 8));
      do_load(5678);
      repeat (4) @(negedge clk);
      check("busy_during_convert", busy, 1);
      ssd  = 13'd42;
      load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      idle(50);

      sb.push_back(frame(0, 0, 4, 2));
      do_load(42);
      idle(50);

      // Reset mid-conversion of 1234: display must come back as zeros.
      do_load(1234);
      repeat (5) @(negedge clk);
      sb.push_back(frame(0, 0, 0, 0));
      #2 reset = 1'b1;
      #1;
      check("midreset_busy", busy, 0);
      check("midreset_anode", Anode, 4'b0111);
      check("midreset_led", LED_out, 7'b0000001);
      @(negedge clk);
      check("midreset_busy_held", busy, 0);
      @(negedge clk);
      reset = 1'b0;
      idle(50);

      // Reset and load together: load is lost.
      @(negedge clk);
      reset = 1'b1;
      load  = 1'b1;
      ssd   = 13'd77;
      @(posedge clk);
      #1 load = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_load_busy", busy, 0);
      @(negedge clk);
      check("reset_load_busy2", busy, 0);

      // Refresh scan and wrap from a fresh reset.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      for (int i = 0; i < 64; i++) begin
         check("refresh_anode_seq", Anode, pat[(i / 4) % 4]);
         if (aidx(Anode) >= 0) cnt[aidx(Anode)]++;
         @(negedge clk);
         #1;
      end
      for (int k = 0; k < 4; k++) check("refresh_digit_cycles", cnt[k], 16);

      idle(5);
      check("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
